// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver, 5..9 data bits, none/odd/even parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit mid-point.
module uart_rx_frame #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic                    uart_rx_ready,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun
);

  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam bit P_ODD  = (PARITY_MODE == 1);
  localparam bit P_EVEN = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_t;

  state_t                  r_state;
  state_t                  w_nstate;
  logic [1:0]              r_sync;
  logic                    r_prev;
  logic [CW-1:0]           r_cnt;
  logic [3:0]              r_bitn;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_par;
  logic                    r_ferr;
  logic                    r_allz;
  logic                    w_rxd;
  logic                    w_tick;
  logic                    w_bit;
  logic                    w_last;
  logic                    w_done;
  logic                    w_brk;
  logic                    w_ferr;
  logic                    w_pxor;
  logic                    w_perr;

  assign w_rxd  = r_sync[1];
  assign w_last = (r_cnt == CW'(CPB - 1));

`ifdef UART_RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == CW'(MID - 1)) r_s0 <= w_rxd;
      if (r_cnt == CW'(MID)) r_s1 <= w_rxd;
    end
  end

  assign w_tick = (r_cnt == CW'(MID + 1));
  assign w_bit  = (r_s0 & r_s1) | (r_s0 & w_rxd) | (r_s1 & w_rxd);
`else
  assign w_tick = (r_cnt == CW'(MID));
  assign w_bit  = w_rxd;
`endif

  // Completion values, meaningful at the last stop-bit sample
  assign w_brk  = r_allz & ~w_bit;
  assign w_ferr = r_ferr | ~w_bit;
  assign w_pxor = (^r_shift) ^ r_par;
  assign w_perr = ~w_brk & ((P_ODD & ~w_pxor) | (P_EVEN & w_pxor));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE:
        if (r_prev && !w_rxd) w_nstate = S_START;
      S_START:
        if (w_tick && w_bit) w_nstate = S_IDLE;
        else if (w_last)     w_nstate = S_DATA;
      S_DATA:
        if (w_last && r_bitn == 4'(PAYLOAD_BITS))
          w_nstate = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY:
        if (w_last) w_nstate = S_STOP;
      S_STOP:
        if (w_tick && r_bitn == 4'(STOP_BITS - 1)) begin
          w_done   = 1'b1;
          w_nstate = w_brk ? S_BRK : S_IDLE;
        end
      S_BRK:
        if (w_rxd) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    if (!uart_rx_en) begin
      w_nstate = S_IDLE;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_ferr  <= 1'b0;
      r_allz  <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], uart_rxd};
      r_prev <= w_rxd;
      if (w_nstate != r_state || r_state == S_IDLE) begin
        r_cnt  <= '0;
        r_bitn <= '0;
      end else begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_tick) r_bitn <= r_bitn + 1'b1;
      end
      if (r_state == S_START) begin
        r_ferr <= 1'b0;
        r_allz <= 1'b1;
      end else if (w_tick) begin
        if (r_state == S_DATA)
          r_shift <= {w_bit, r_shift[PAYLOAD_BITS-1:1]};
        if (r_state == S_PARITY) r_par <= w_bit;
        if (r_state == S_STOP && !w_bit) r_ferr <= 1'b1;
        if (r_state inside {S_DATA, S_PARITY, S_STOP})
          r_allz <= r_allz & ~w_bit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
      uart_rx_overrun    <= 1'b0;
    end else begin
      uart_rx_overrun <= 1'b0;
      if (w_done && (!uart_rx_valid || uart_rx_ready)) begin
        uart_rx_valid      <= 1'b1;
        uart_rx_data       <= r_shift;
        uart_rx_parity_err <= w_perr;
        uart_rx_frame_err  <= w_ferr;
        uart_rx_break      <= w_brk;
      end else begin
        if (w_done) uart_rx_overrun <= 1'b1;
        if (uart_rx_ready) uart_rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames into an 8N1 receiver and a 7E2 receiver.
// Words are captured on the falling edge whenever valid && ready.
module tb_uart_rx_frame;

  localparam int CPB = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       rxd_a = 1'b1, en_a = 1'b1, rdy_a = 1'b1;
  logic       val_a, perr_a, ferr_a, brk_a, ovr_a;
  logic [7:0] data_a;

  logic       rxd_b = 1'b1, en_b = 1'b1, rdy_b = 1'b1;
  logic       val_b, perr_b, ferr_b, brk_b, ovr_b;
  logic [6:0] data_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int words_a = 0, words_b = 0;
  int vhigh_a = 0, ovr_cnt_a = 0, rise_a = -1;
  logic       prev_val_a = 1'b0;
  logic [7:0] cap_d_a = '0;
  logic [2:0] cap_f_a = '0;
  logic [6:0] cap_d_b = '0;
  logic [2:0] cap_f_b = '0;

  uart_rx_frame #(
    .CLK_HZ(50_000_000), .BIT_RATE(1_000_000),
    .PAYLOAD_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .uart_rxd(rxd_a),
    .uart_rx_en(en_a), .uart_rx_ready(rdy_a),
    .uart_rx_valid(val_a), .uart_rx_data(data_a),
    .uart_rx_parity_err(perr_a), .uart_rx_frame_err(ferr_a),
    .uart_rx_break(brk_a), .uart_rx_overrun(ovr_a)
  );

  uart_rx_frame #(
    .CLK_HZ(50_000_000), .BIT_RATE(1_000_000),
    .PAYLOAD_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)
  ) dut_b (
    .clk(clk), .reset(reset), .uart_rxd(rxd_b),
    .uart_rx_en(en_b), .uart_rx_ready(rdy_b),
    .uart_rx_valid(val_b), .uart_rx_data(data_b),
    .uart_rx_parity_err(perr_b), .uart_rx_frame_err(ferr_b),
    .uart_rx_break(brk_b), .uart_rx_overrun(ovr_b)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (val_a) vhigh_a++;
    if (val_a && !prev_val_a) rise_a = cyc;
    prev_val_a = val_a;
    if (ovr_a) ovr_cnt_a++;
    if (val_a && rdy_a) begin
      words_a++;
      cap_d_a = data_a;
      cap_f_a = {perr_a, ferr_a, brk_a};
    end
    if (val_b && rdy_b) begin
      words_b++;
      cap_d_b = data_b;
      cap_f_b = {perr_b, ferr_b, brk_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) rxd_a = v;
    else        rxd_b = v;
  endtask

  task automatic send(input int w, input logic [8:0] d, input int nb,
                      input int np, input logic p,
                      input logic [1:0] stp, input int ns);
    set_line(w, 1'b0);
    tick(CPB);
    for (int i = 0; i < nb; i++) begin
      set_line(w, d[i]);
      tick(CPB);
    end
    if (np != 0) begin
      set_line(w, p);
      tick(CPB);
    end
    for (int i = 0; i < ns; i++) begin
      set_line(w, stp[i]);
      tick(CPB);
    end
    set_line(w, 1'b1);
  endtask

  initial begin
    int w0, v0, c0, o0, lat;

    tick(3);
    chk("rst_valid_a", val_a, 0);
    chk("rst_data_a", data_a, 0);
    chk("rst_flags_a", {perr_a, ferr_a, brk_a, ovr_a}, 0);
    chk("rst_valid_b", val_b, 0);
    chk("rst_data_b", data_b, 0);
    reset = 1'b0;
    tick(5);

    // 8N1 0xA5, ready held high
    w0 = words_a; v0 = vhigh_a; c0 = cyc;
    send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
    tick(2 * CPB);
    lat = rise_a - c0;
    chk("a5_words", words_a - w0, 1);
    chk("a5_data", cap_d_a, 8'hA5);
    chk("a5_flags", cap_f_a, 3'b000);
    chk("a5_width", vhigh_a - v0, 1);
    chk("a5_latency_in_window", (lat >= 478 && lat <= 480), 1);

    // 7E2: 0x35 has four ones, so parity 1 is wrong and parity 0 is right
    w0 = words_b;
    send(1, 9'h035, 7, 1, 1'b1, 2'b11, 2);
    tick(2 * CPB);
    chk("p1_words", words_b - w0, 1);
    chk("p1_data", cap_d_b, 7'h35);
    chk("p1_flags", cap_f_b, 3'b100);
    send(1, 9'h035, 7, 1, 1'b0, 2'b11, 2);
    tick(2 * CPB);
    chk("p0_words", words_b - w0, 2);
    chk("p0_data", cap_d_b, 7'h35);
    chk("p0_flags", cap_f_b, 3'b000);

    // second stop bit low, then a clean frame
    send(1, 9'h03C, 7, 1, 1'b0, 2'b01, 2);
    tick(2 * CPB);
    chk("fe_words", words_b - w0, 3);
    chk("fe_data", cap_d_b, 7'h3C);
    chk("fe_flags", cap_f_b, 3'b010);
    send(1, 9'h011, 7, 1, 1'b0, 2'b11, 2);
    tick(2 * CPB);
    chk("ok_words", words_b - w0, 4);
    chk("ok_data", cap_d_b, 7'h11);
    chk("ok_flags", cap_f_b, 3'b000);

    // break: 20 bit times low
    w0 = words_a;
    rxd_a = 1'b0;
    tick(20 * CPB);
    rxd_a = 1'b1;
    tick(3 * CPB);
    chk("brk_words", words_a - w0, 1);
    chk("brk_data", cap_d_a, 8'h00);
    chk("brk_flags", cap_f_a, 3'b011);
    send(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
    tick(2 * CPB);
    chk("post_brk_words", words_a - w0, 2);
    chk("post_brk_data", cap_d_a, 8'h3C);
    chk("post_brk_flags", cap_f_a, 3'b000);

    // overrun: ready low, two back-to-back frames
    rdy_a = 1'b0;
    w0 = words_a; o0 = ovr_cnt_a;
    send(0, 9'h012, 8, 0, 1'b0, 2'b11, 1);
    send(0, 9'h034, 8, 0, 1'b0, 2'b11, 1);
    tick(2 * CPB);
    chk("ovr_valid", val_a, 1);
    chk("ovr_held", data_a, 8'h12);
    chk("ovr_pulses", ovr_cnt_a - o0, 1);
    rdy_a = 1'b1;
    tick(1);
    chk("ovr_drop", val_a, 0);
    chk("ovr_words", words_a - w0, 1);
    chk("ovr_data", cap_d_a, 8'h12);
    tick(CPB);
    chk("ovr_no_more", words_a - w0, 1);

    // false start: 10-cycle low glitch
    w0 = words_a;
    rxd_a = 1'b0;
    tick(10);
    rxd_a = 1'b1;
    tick(2 * CPB);
    chk("fs_words", words_a - w0, 0);
    chk("fs_valid", val_a, 0);
    send(0, 9'h05A, 8, 0, 1'b0, 2'b11, 1);
    tick(2 * CPB);
    chk("fs_recover", cap_d_a, 8'h5A);

    // enable dropped mid-frame discards the partial 0xFF
    w0 = words_a;
    rxd_a = 1'b0;
    tick(CPB);
    rxd_a = 1'b1;
    tick(2 * CPB);
    en_a = 1'b0;
    tick(3);
    en_a = 1'b1;
    tick(8 * CPB);
    chk("en_words", words_a - w0, 0);
    send(0, 9'h081, 8, 0, 1'b0, 2'b11, 1);
    tick(2 * CPB);
    chk("en_recover_words", words_a - w0, 1);
    chk("en_recover_data", cap_d_a, 8'h81);

`ifdef UART_RX_MAJORITY_EN
    // single-cycle high glitch inside data bit 3 of 0x00
    w0 = words_a;
    rxd_a = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_a = 1'b0;
      if (i == 3) begin
        tick(26);
        rxd_a = 1'b1;
        tick(1);
        rxd_a = 1'b0;
        tick(CPB - 27);
      end else begin
        tick(CPB);
      end
    end
    rxd_a = 1'b1;
    tick(3 * CPB);
    chk("maj_words", words_a - w0, 1);
    chk("maj_data", cap_d_a, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
